// File: rtl/simplecpu_boot_loader_if.sv
// Byte-stream input and RAM/CPU control bundle of the SimpleCPU boot loader.
// The loader sits on the slave side. The stream source and RAM mux sit on the master side.
interface simplecpu_boot_loader_if #(
  parameter int unsigned SIZE = 10
);
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            ram_sel;
  logic            ram_we;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_data;
  logic            cpu_rst;
  logic            done;
  logic            err;

  modport master (
    output in_valid, in_data,
    input  in_ready, ram_sel, ram_we, ram_addr, ram_data, cpu_rst, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_sel, ram_we, ram_addr, ram_data, cpu_rst, done, err
  );
endinterface

// File: rtl/simplecpu_boot_loader.sv
// Loads a checksummed big-endian program image from a byte stream into BRAM.
// Holds SimpleCPU in reset until the image is verified.
module simplecpu_boot_loader #(
  parameter int unsigned SIZE  = 10,
  parameter int unsigned DEPTH = 1024
) (
  input logic                     clk,
  input logic                     rst,
  simplecpu_boot_loader_if.slave  bus
);

  localparam logic [2:0] S_CNTH  = 3'd0;
  localparam logic [2:0] S_CNTL  = 3'd1;
  localparam logic [2:0] S_WORD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]  state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] widx, widx_nxt;
  logic [1:0]  bidx, bidx_nxt;
  logic [31:0] shift, shift_nxt;
  logic [7:0]  sum, sum_nxt;
  logic        accept;

  logic            in_ready_nxt;
  logic            ram_sel_nxt;
  logic            ram_we_nxt;
  logic [SIZE-1:0] ram_addr_nxt;
  logic [31:0]     ram_data_nxt;
  logic            cpu_rst_nxt;
  logic            done_nxt;
  logic            err_nxt;

  // State register, datapath registers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_CNTH;
      cnt           <= '0;
      widx          <= '0;
      bidx          <= '0;
      shift         <= '0;
      sum           <= '0;
      bus.in_ready  <= 1'b0;
      bus.ram_sel   <= 1'b1;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_data  <= '0;
      bus.cpu_rst   <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      widx          <= widx_nxt;
      bidx          <= bidx_nxt;
      shift         <= shift_nxt;
      sum           <= sum_nxt;
      bus.in_ready  <= in_ready_nxt;
      bus.ram_sel   <= ram_sel_nxt;
      bus.ram_we    <= ram_we_nxt;
      bus.ram_addr  <= ram_addr_nxt;
      bus.ram_data  <= ram_data_nxt;
      bus.cpu_rst   <= cpu_rst_nxt;
      bus.done      <= done_nxt;
      bus.err       <= err_nxt;
    end
  end

  // Next state and next register values; outputs are decoded from the next state
  // so each registered output lines up with the state it belongs to.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    widx_nxt  = widx;
    bidx_nxt  = bidx;
    shift_nxt = shift;
    sum_nxt   = sum;
    accept    = bus.in_valid && bus.in_ready;

    case (state)
      S_CNTH: begin
        if (accept) begin
          cnt_nxt   = {bus.in_data, cnt[7:0]};
          sum_nxt   = sum + bus.in_data;
          state_nxt = S_CNTL;
        end
      end
      S_CNTL: begin
        if (accept) begin
          cnt_nxt = {cnt[15:8], bus.in_data};
          sum_nxt = sum + bus.in_data;
          if (32'(cnt_nxt) > DEPTH) begin
            state_nxt = S_ERR;
          end else if (cnt_nxt == 16'd0) begin
            state_nxt = S_CSUM;
          end else begin
            state_nxt = S_WORD;
          end
        end
      end
      S_WORD: begin
        if (accept) begin
          shift_nxt = {shift[23:0], bus.in_data};
          sum_nxt   = sum + bus.in_data;
          bidx_nxt  = bidx + 2'd1;
          if (bidx == 2'd3) begin
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        widx_nxt  = widx + 16'd1;
        state_nxt = (widx_nxt == cnt) ? S_CSUM : S_WORD;
      end
      S_CSUM: begin
        if (accept) begin
          state_nxt = (bus.in_data == sum) ? S_RUN : S_ERR;
        end
      end
      S_RUN: begin
        state_nxt = S_RUN;
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_ERR;
      end
    endcase

    in_ready_nxt = (state_nxt == S_CNTH) || (state_nxt == S_CNTL) ||
                   (state_nxt == S_WORD) || (state_nxt == S_CSUM);
    ram_we_nxt   = (state_nxt == S_WRITE);
    ram_addr_nxt = ram_we_nxt ? widx_nxt[SIZE-1:0] : '0;
    ram_data_nxt = ram_we_nxt ? shift_nxt : 32'd0;
    ram_sel_nxt  = (state_nxt != S_RUN);
    cpu_rst_nxt  = (state_nxt != S_RUN);
    done_nxt     = (state_nxt == S_RUN);
    err_nxt      = (state_nxt == S_ERR);
  end

endmodule

// File: tb/tb_simplecpu_boot_loader.sv
// Bench for simplecpu_boot_loader: directed image table, reset/latency sequence,
// maximum-size image and randomized images checked against a stream-level model.
module tb_simplecpu_boot_loader;

  localparam int unsigned SIZE  = 10;
  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  simplecpu_boot_loader_if #(.SIZE(SIZE)) bus ();

  simplecpu_boot_loader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [SIZE-1:0] wr_addr[$];
  logic [31:0]     wr_data[$];

  typedef struct {
    string       name;
    int          len;
    logic [95:0] bytes;
    bit          gapped;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          done_e;
    bit          err_e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Log every RAM write; the stream must be held off while a write is in flight
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      wr_addr.push_back(bus.ram_addr);
      wr_data.push_back(bus.ram_data);
      check("ready_during_write", 64'(bus.in_ready), 64'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Offer one byte until accepted; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b, input bit gapped, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    if (gapped) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (n < 50) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  // Stream-level reference: what an image should produce
  function automatic void model(input logic [7:0] s[$], output bit d, output bit e,
                                output logic [31:0] w[$]);
    int unsigned n;
    int unsigned total;
    n     = {s[0], s[1]};
    total = 0;
    w.delete();
    d = 1'b0;
    e = 1'b0;
    if (n > DEPTH) begin
      e = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++)
      w.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
    for (int i = 0; i < s.size() - 1; i++) total += s[i];
    if ((total % 256) == int'(s[s.size()-1])) d = 1'b1;
    else e = 1'b1;
  endfunction

  task automatic gen(input int unsigned n, input bit corrupt, output logic [7:0] s[$]);
    logic [7:0] sm;
    s.delete();
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    if (n > DEPTH) return;
    for (int i = 0; i < int'(4 * n); i++) s.push_back(8'($urandom));
    sm = 8'd0;
    foreach (s[i]) sm = sm + s[i];
    if (corrupt) sm = sm + 8'($urandom_range(1, 255));
    s.push_back(sm);
  endtask

  task automatic run_image(input string tag, input logic [7:0] s[$], input bit gapped,
                           input bit done_e, input bit err_e, input logic [31:0] w[$]);
    bit ok;
    bit any_ready;
    int m;
    do_reset();
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i], gapped, ok);
      if (!ok) begin
        check({tag, "_accept_timeout"}, 64'd0, 64'd1);
        break;
      end
    end
    check({tag, "_done"},    64'(bus.done),    64'(done_e));
    check({tag, "_err"},     64'(bus.err),     64'(err_e));
    check({tag, "_cpu_rst"}, 64'(bus.cpu_rst), 64'(!done_e));
    check({tag, "_ram_sel"}, 64'(bus.ram_sel), 64'(!done_e));
    any_ready = 1'b0;
    repeat (6) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      any_ready = any_ready | (bus.in_ready === 1'b1);
    end
    bus.in_valid = 1'b0;
    check({tag, "_no_ready"}, 64'(any_ready), 64'd0);
    check({tag, "_done_hold"}, 64'(bus.done), 64'(done_e));
    check({tag, "_nwr"}, 64'(wr_addr.size()), 64'(w.size()));
    m = (wr_addr.size() < w.size()) ? wr_addr.size() : w.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_addr"}, 64'(wr_addr[i]), 64'(i));
      check({tag, "_data"}, 64'(wr_data[i]), 64'(w[i]));
    end
  endtask

  initial begin
    vec_t        tbl[5];
    logic [7:0]  s[$];
    logic [31:0] w[$];
    logic [95:0] two;
    bit          ok;
    bit          d;
    bit          e;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    tbl[0] = '{"two_word",  11, 96'h00_02_20_11_40_45_10_11_40_01_1A_00, 1'b0, 2,
               32'h20114045, 32'h10114001, 1'b1, 1'b0};
    tbl[1] = '{"empty",      3, 96'h00_00_00_00_00_00_00_00_00_00_00_00, 1'b0, 0,
               32'h0, 32'h0, 1'b1, 1'b0};
    tbl[2] = '{"oversize",   2, 96'h04_01_00_00_00_00_00_00_00_00_00_00, 1'b0, 0,
               32'h0, 32'h0, 1'b0, 1'b1};
    tbl[3] = '{"bad_csum",  11, 96'h00_02_20_11_40_45_10_11_40_01_1B_00, 1'b0, 2,
               32'h20114045, 32'h10114001, 1'b0, 1'b1};
    tbl[4] = '{"gapped",    11, 96'h00_02_20_11_40_45_10_11_40_01_1A_00, 1'b1, 2,
               32'h20114045, 32'h10114001, 1'b1, 1'b0};

    for (int t = 0; t < 5; t++) begin
      s.delete();
      w.delete();
      for (int k = 0; k < tbl[t].len; k++) s.push_back(tbl[t].bytes[95-8*k -: 8]);
      if (tbl[t].nwr > 0) w.push_back(tbl[t].w0);
      if (tbl[t].nwr > 1) w.push_back(tbl[t].w1);
      run_image(tbl[t].name, s, tbl[t].gapped, tbl[t].done_e, tbl[t].err_e, w);
    end

    // First-write latency, then a reset in the middle of the load
    two = 96'h00_02_20_11_40_45_10_11_40_01_1A_00;
    do_reset();
    for (int k = 0; k < 6; k++) send_byte(two[95-8*k -: 8], 1'b0, ok);
    check("lat_we",   64'(bus.ram_we),   64'd1);
    check("lat_addr", 64'(bus.ram_addr), 64'd0);
    check("lat_data", 64'(bus.ram_data), 64'h20114045);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_ram_sel",  64'(bus.ram_sel),  64'd1);
    check("rst_ram_we",   64'(bus.ram_we),   64'd0);
    check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("rst_ram_data", 64'(bus.ram_data), 64'd0);
    check("rst_cpu_rst",  64'(bus.cpu_rst),  64'd1);
    check("rst_done",     64'(bus.done),     64'd0);
    check("rst_err",      64'(bus.err),      64'd0);
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    check("rst_ready_back", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 11; k++) send_byte(two[95-8*k -: 8], 1'b0, ok);
    check("reload_done",    64'(bus.done),    64'd1);
    check("reload_cpu_rst", 64'(bus.cpu_rst), 64'd0);
    check("reload_nwr",     64'(wr_addr.size()), 64'd2);

    // Largest legal image: last word lands at DEPTH-1
    gen(DEPTH, 1'b0, s);
    model(s, d, e, w);
    run_image("max_depth", s, 1'b0, d, e, w);

    // Randomized images, gaps and corrupted checksums
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 7) == 0)
        gen(DEPTH + 1 + $urandom_range(0, 65535 - DEPTH - 1), 1'b0, s);
      else
        gen($urandom_range(0, 6), ($urandom_range(0, 3) == 0), s);
      model(s, d, e, w);
      run_image("rand", s, 1'($urandom_range(0, 1)), d, e, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simplecpu_boot_loader.md
Name: simplecpu_boot_loader

Overview:
- Upstream stage of the SimpleCPU/blram pair. Receives a program image as a byte stream with a valid/ready handshake, packs the bytes into 32-bit words and writes them into the BRAM starting at address 0.
- Holds the CPU in reset and owns the RAM port for the whole load.
- After a checksum-verified image, hands the RAM to the CPU and releases CPU reset. A bad or oversized image is latched as an error and the CPU stays in reset.

Parameters:
- SIZE, 10, RAM address width; must match the CPU/blram SIZE.
- DEPTH, 1024, number of RAM words; the maximum loadable word count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts the byte this cycle.
- ram_sel  output  1  1 = loader drives the RAM port; 0 = CPU drives it (external mux).
- ram_we  output  1  RAM write enable.
- ram_addr  output  SIZE  RAM word address.
- ram_data  output  32  RAM write data.
- cpu_rst  output  1  reset to SimpleCPU; active-high.
- done  output  1  image loaded and verified; CPU running.
- err  output  1  image rejected.

Behaviour:
- Byte transfer: a byte is accepted only in a cycle where in_valid && in_ready. in_data is ignored in all other cycles.
- Stream format, in order:
  - CNT_H, CNT_L: 16-bit word count N, big-endian.
  - 4*N data bytes: each word is big-endian, so the first byte lands in [31:24].
  - CSUM: one byte equal to the mod-256 sum of every preceding byte, including the count bytes.
- Internal registers:
  - state.
  - cnt[15:0].
  - widx: word index, 16 bits.
  - bidx[1:0].
  - shift[31:0].
  - sum[7:0].
- While rst = 1 (takes effect at the clock edge):
  - state = S_CNTH; cnt, widx, bidx, shift and sum cleared.
  - Outputs: in_ready=0, ram_sel=1, ram_we=0, ram_addr=0, ram_data=0, cpu_rst=1, done=0, err=0.
- States and outputs:
  - S_CNTH: in_ready=1. On accept: cnt[15:8] = byte, sum = sum + byte, go to S_CNTL.
  - S_CNTL: in_ready=1. On accept: cnt[7:0] = byte, sum updated. Next state:
    - full count > DEPTH: S_ERR;
    - count == 0: S_CSUM;
    - otherwise: S_WORD.
  - S_WORD: in_ready=1. On accept: shift = {shift[23:0], byte}, sum updated, bidx incremented. On the 4th byte (bidx==3): go to S_WRITE.
  - S_WRITE: in_ready=0, ram_we=1, ram_addr = widx[SIZE-1:0], ram_data = shift. Exactly one cycle. Then:
    - widx += 1;
    - if widx+1 == cnt: S_CSUM;
    - else: S_WORD.
  - S_CSUM: in_ready=1. On accept:
    - byte == sum: S_RUN;
    - byte != sum: S_ERR.
  - S_RUN: in_ready=0, ram_sel=0, cpu_rst=0, done=1, ram_we=0. Terminal; only rst leaves this state.
  - S_ERR: in_ready=0, ram_sel=1, cpu_rst=1, err=1, ram_we=0. Terminal; only rst leaves this state.
- Outputs outside S_WRITE: ram_we=0, ram_addr=0, ram_data=0.
- cpu_rst=1 and ram_sel=1 in every state except S_RUN.
- Outputs are a pure function of the registered state and registers; no combinational path from in_valid to in_ready.
- Latency:
  - The first RAM write occurs 1 cycle after the 4th data byte is accepted.
  - cpu_rst falls 1 cycle after an accepted checksum byte that matches.
  - Minimum load time: 2 + 5*N + 1 cycles.
- Gaps and backpressure: in_valid may drop at any point with no effect on state. Stray bytes offered in S_WRITE are held off by in_ready=0.
- Memory beyond the loaded image: words at addresses ≥ N are never written.
- Reset mid-load: the image restarts from S_CNTH. Words already written stay in RAM and are overwritten by the next load.
- Count of exactly DEPTH is legal: the last write goes to address DEPTH-1.

Test Plan:
- Two-word load:
  - Stream 00 02 20 11 40 45 10 11 40 01 1A with no gaps.
  - Required: ram_we pulses at addr 0 with data 20114045 and at addr 1 with data 10114001.
  - Required: one cycle after byte 1A is accepted, cpu_rst=0, ram_sel=0, done=1.
  - Required: no further in_ready.
- Empty image:
  - Stream 00 00 00.
  - Required: no ram_we pulses; done=1, cpu_rst=0.
- Oversize count:
  - Stream 04 01 (count 1025).
  - Required: err=1 the cycle after 01 is accepted; in_ready=0 from then on; no ram_we ever; cpu_rst stays 1.
- Bad checksum:
  - Same stream as the two-word load but with final byte 1B.
  - Required: both words are written; then err=1, done=0, cpu_rst=1.
- Backpressure and gaps:
  - Run the two-word load with in_valid toggling randomly.
  - Required: identical RAM writes and end state to the gap-free run; in_ready=0 during each S_WRITE cycle.
- Reset mid-load:
  - Assert rst for 1 cycle after the 6th byte of the two-word load, then send the full stream again.
  - Required: after the rst cycle, outputs are at their reset values and the state is S_CNTH.
  - Required: the reload completes with done=1 and exactly 2 write pulses after reset.
